// File: rtl/conv_sum_tree.sv
// conv_sum_tree
//   Pipelined 9-input adder tree followed by a channel accumulator. Each
//   accepted beat carries nine signed 16-bit products of one 3x3 window.
//   The block adds them, accumulates across ch_num channels starting from a
//   bias, and emits one saturated (optionally ReLU-clamped) 16-bit result
//   per group. A global stall freezes every register in the block.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over stall)
//   stall      freezes all state while high
//   in_valid   beat qualifier for mul_result
//   mul_result 9 x HWORD signed products
//   bias       signed bias, latched on the first beat of a group
//   ch_num     channels per group, latched on the first beat (0 acts as 1)
//   relu_en    ReLU enable, latched on the first beat of a group
//   out_valid  result qualifier (consumer qualifies with !stall)
//   out_data   signed saturated result
//   busy       group in progress or pipeline occupied
module conv_sum_tree #(
  parameter int ACC_W = 28,
  parameter int CH_W  = 8,
  parameter int HWORD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic [8:0][HWORD-1:0] mul_result,
  input  logic [15:0]           bias,
  input  logic [CH_W-1:0]       ch_num,
  input  logic                  relu_en,
  output logic                  out_valid,
  output logic [15:0]           out_data,
  output logic                  busy
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;  // -32768

  // ---------------------------------------------------------------------
  // Input side: group parameters are taken from the ports on the first
  // beat of a group and then attached to every beat of that group, so the
  // accumulator always sees the parameters of the group it is working on,
  // even when the next group has already started entering the tree.
  // ---------------------------------------------------------------------
  logic [CH_W-1:0] in_cnt_reg;
  logic [15:0]     grp_bias_reg;
  logic [CH_W-1:0] grp_ch_reg;
  logic            grp_relu_reg;

  logic            in_first;
  logic            in_last;
  logic [CH_W-1:0] ch_eff;
  logic [15:0]     beat_bias;
  logic [CH_W-1:0] beat_ch;
  logic            beat_relu;

  assign in_first  = (in_cnt_reg == '0);
  assign ch_eff    = (ch_num == '0) ? CH_W'(1) : ch_num;
  assign beat_bias = in_first ? bias    : grp_bias_reg;
  assign beat_ch   = in_first ? ch_eff  : grp_ch_reg;
  assign beat_relu = in_first ? relu_en : grp_relu_reg;
  assign in_last   = (in_cnt_reg == beat_ch - CH_W'(1));

  // ---------------------------------------------------------------------
  // Adder tree: 17-bit pair sums, 18-bit quad sums, 20-bit total.
  // ---------------------------------------------------------------------
  logic             v1_reg, v2_reg, v3_reg;
  logic [16:0]      s1_sum_reg [4];
  logic [15:0]      s1_p8_reg;
  logic [17:0]      s2_sum_reg [2];
  logic [15:0]      s2_p8_reg;
  logic [19:0]      s3_sum_reg;

  logic [16:0]      s1_sum_next [4];
  logic [17:0]      s2_sum_next [2];
  logic [19:0]      s3_sum_next;

  // Group parameters riding alongside the beats through S1..S3.
  logic [15:0]      bias_pipe_reg [3];
  logic [CH_W-1:0]  ch_pipe_reg   [3];
  logic             relu_pipe_reg [3];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_s1
      assign s1_sum_next[gi] = {mul_result[2*gi][HWORD-1],   mul_result[2*gi]}
                             + {mul_result[2*gi+1][HWORD-1], mul_result[2*gi+1]};
    end
    for (gi = 0; gi < 2; gi++) begin : g_s2
      assign s2_sum_next[gi] = {s1_sum_reg[2*gi][16],   s1_sum_reg[2*gi]}
                             + {s1_sum_reg[2*gi+1][16], s1_sum_reg[2*gi+1]};
    end
  endgenerate

  assign s3_sum_next = {{2{s2_sum_reg[0][17]}}, s2_sum_reg[0]}
                     + {{2{s2_sum_reg[1][17]}}, s2_sum_reg[1]}
                     + {{4{s2_p8_reg[15]}},     s2_p8_reg};

  // Datapath registers carry no reset: the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sum_reg       <= s1_sum_next;
      s1_p8_reg        <= mul_result[8];
      s2_sum_reg       <= s2_sum_next;
      s2_p8_reg        <= s1_p8_reg;
      s3_sum_reg       <= s3_sum_next;
      bias_pipe_reg[0] <= beat_bias;
      ch_pipe_reg[0]   <= beat_ch;
      relu_pipe_reg[0] <= beat_relu;
      for (int i = 1; i < 3; i++) begin
        bias_pipe_reg[i] <= bias_pipe_reg[i-1];
        ch_pipe_reg[i]   <= ch_pipe_reg[i-1];
        relu_pipe_reg[i] <= relu_pipe_reg[i-1];
      end
      if (in_valid && in_first) begin
        grp_bias_reg <= bias;
        grp_ch_reg   <= ch_eff;
        grp_relu_reg <= relu_en;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Accumulator stage
  // ---------------------------------------------------------------------
  logic [CH_W-1:0]         cnt_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [ACC_W-1:0]        acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic                    acc_last;
  logic [15:0]             sat_val;
  logic [15:0]             res_val;

  assign acc_base = (cnt_reg == '0)
                  ? {{(ACC_W-16){bias_pipe_reg[2][15]}}, bias_pipe_reg[2]}
                  : acc_reg;
  assign acc_next = acc_base + {{(ACC_W-20){s3_sum_reg[19]}}, s3_sum_reg};
  assign acc_last = (cnt_reg == ch_pipe_reg[2] - CH_W'(1));

  always_comb begin
    sat_val = acc_next[15:0];
    if (acc_next > SAT_MAX) begin
      sat_val = 16'h7FFF;
    end else if (acc_next < SAT_MIN) begin
      sat_val = 16'h8000;
    end
  end

  // ReLU acts on the already saturated value.
  assign res_val = (relu_pipe_reg[2] && sat_val[15]) ? 16'h0000 : sat_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      in_cnt_reg <= '0;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (!stall) begin
      v1_reg    <= in_valid;
      v2_reg    <= v1_reg;
      v3_reg    <= v2_reg;
      out_valid <= 1'b0;
      if (in_valid) begin
        in_cnt_reg <= in_last ? '0 : in_cnt_reg + CH_W'(1);
      end
      if (v3_reg) begin
        acc_reg <= acc_next;
        if (acc_last) begin
          cnt_reg   <= '0;
          out_valid <= 1'b1;
          out_data  <= res_val;
        end else begin
          cnt_reg <= cnt_reg + CH_W'(1);
        end
      end
    end
  end

  assign busy = (cnt_reg != '0) | v1_reg | v2_reg | v3_reg;

endmodule

// File: doc/conv_sum_tree.md
# conv_sum_tree

Pipelined 9-input adder tree and channel accumulator directly downstream of the DLA product register stage. Each accepted beat carries nine signed 16-bit products of one 3x3 kernel window. The block sums them and accumulates the sum across `ch_num` input channels starting from a bias. At group end it emits one saturated, optionally ReLU-clamped 16-bit result. It shares the global `stall` with the product stage so the two stages freeze together.

## Interface
- `ACC_W`, 28: accumulator width in bits; holds 9 x 32768 x 255 without overflow.
- `CH_W`, 8: width of the channel-count input.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  freezes every register in the block while high.
- `in_valid`  in  1  beat qualifier for `mul_result`.
- `mul_result[8:0]`  in  9 x `HWORD` (16)  signed two's-complement products.
- `bias`  in  16  signed; latched on the first beat of a group.
- `ch_num`  in  `CH_W`  channels per group; latched on the first beat; 0 is treated as 1.
- `relu_en`  in  1  latched on the first beat of a group.
- `out_valid`  out  1  result qualifier.
- `out_data`  out  16  signed saturated result.
- `busy`  out  1  high when `cnt != 0` or any pipeline valid bit is set.

## Operation
- An input beat is accepted on an edge where `in_valid=1`, `stall=0` and `rst=0`. There is no backpressure output.
- **S1:** registers four pair sums (p0+p1, p2+p3, p4+p5, p6+p7) at 17 bits and passes p8 through, plus a valid bit.
- **S2:** registers two sums at 18 bits and passes p8 through, plus a valid bit.
- **S3:** registers the full sign-extended tree sum at 20 bits, plus a valid bit.
- **ACC stage:** acts on a valid S3 beat.
  - If `cnt == 0`: `acc <= sext(bias_l) + sum`.
  - Otherwise: `acc <= acc + sum`.
  - `cnt` increments on each beat.
  - When `cnt == ch_l-1`, the beat ends the group:
    - `cnt` returns to 0.
    - `out_data <= relu(sat16(acc_next))` and `out_valid <= 1`.
  - On all other edges `out_valid <= 0`.
- **Latched values:** `bias_l`, `ch_l` and `relu_l` are captured from the inputs when a first beat (`cnt == 0` at the ACC stage) is accepted at input. This uses an input-side counter `in_cnt` that mirrors `cnt`, so a group's parameters travel with it. Changing the inputs mid-group has no effect.
- **sat16:** clamps to the range [-32768, 32767].
- **relu:** when `relu_l=1`, negative values become 0. It is applied after saturation.
- All arithmetic is integer; no rounding or shifting is performed.
- Bubbles (`in_valid=0`) between beats of a group are allowed. Bubble cycles do not advance `cnt`.

## Timing
- **Latency:** when the last beat of a group is accepted at edge N, `out_valid=1` and `out_data` are visible after edge N+3 (4 register levels), for exactly one unstalled cycle.
- **Throughput:** one beat per cycle. With `ch_num=1`, back-to-back beats produce one result per cycle.
- **Stall:** while `stall=1`, all pipeline registers, valid bits, `acc`, `cnt`, `in_cnt`, latched parameters, `out_data` and `out_valid` hold their values, and inputs are ignored. The consumer therefore qualifies `out_valid` with `!stall`. After `stall` falls, the pipeline resumes exactly where it stopped.
- **Reset:**
  - Reset has priority over `stall`.
  - On reset, all valid bits, `cnt`, `in_cnt` and `acc` are cleared to 0, and `out_data=0`, `out_valid=0`, `busy=0`.
  - A group in flight is discarded.
  - The first beat accepted after reset starts a new group.
- **`ch_num` boundaries:**
  - `ch_num=0` behaves as 1.
  - `ch_num=255` is the maximum; no accumulator overflow is possible at `ACC_W=28`.

## Test plan
- **Single beat:** all products = 1, `bias=0`, `ch_num=1`, `relu_en=0`, one beat at edge N -> `out_data=9`, `out_valid` high after edge N+3 for one cycle only.
- **Multi-channel with bubble:** `ch_num=3`, `bias=-50`, three beats of all-100 products with one bubble between beats 2 and 3 -> one output, `out_data=2650`, 4 cycles after the third beat.
- **Saturation and ReLU:**
  - All products 32767, `ch_num=2` -> `out_data=32767`.
  - All products -32768, `relu_en=0` -> `out_data=-32768`.
  - All products -32768, `relu_en=1` -> `out_data=0`.
- **Stall mid-flight:** with the case-1 stimulus, assert `stall` for 2 cycles one edge after acceptance -> `out_data=9` appears 2 cycles later than in case 1, and `out_valid` holds high while `stall` is high over it.
- **Reset mid-group:**
  - `ch_num=4`, two beats of all-10 products, then `rst` for one cycle -> `out_valid` stays 0 and `busy=0`.
  - Then `ch_num=1`, `bias=5`, one beat of all-1 products -> `out_data=14`.
- **Back-to-back groups:** `ch_num=1`, 8 consecutive beats with products k=1..8 -> 8 consecutive `out_valid` cycles with `out_data=9k`, in order.
